// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared cpu defines for the instruction fetch unit
package instr_fetch_unit_pkg;
  localparam int WORD_LENGTH = 32;
  localparam int SEG_W = 16;
  localparam logic [WORD_LENGTH-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {
    TRAP_NONE   = 2'd0,
    TRAP_ALIGN  = 2'd1,
    TRAP_ACCESS = 2'd2,
    TRAP_TMO    = 2'd3
  } trap_e;
  typedef enum logic [2:0] {FS_IDLE, FS_REQ, FS_WAIT, FS_HOLD, FS_DRAIN} fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: one I-cache fetch per accepted PSTATE pair, presented to the FD register
module instr_fetch_unit #(
  parameter int WORD_LENGTH = instr_fetch_unit_pkg::WORD_LENGTH,
  parameter int SEG_W = instr_fetch_unit_pkg::SEG_W,
  parameter int TMO_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iaValid,
  output logic                   iaReady,
  input  logic [WORD_LENGTH-1:0] iaPstate0,
  input  logic [WORD_LENGTH-1:0] iaPstate1,
  input  logic                   flush,
  output logic                   icReq,
  input  logic                   icReqAck,
  output logic [SEG_W-1:0]       icSeg,
  output logic [WORD_LENGTH-1:0] icOfs,
  input  logic                   icRspValid,
  input  logic [WORD_LENGTH-1:0] icRspData,
  input  logic                   icRspErr,
  output logic                   fdValid,
  input  logic                   fdStall,
  output logic [WORD_LENGTH-1:0] fdPstate0,
  output logic [WORD_LENGTH-1:0] fdPstate1,
  output logic [WORD_LENGTH-1:0] fdInstr,
  output logic                   fdTrap,
  output logic [1:0]             fdTrapCode
);
  import instr_fetch_unit_pkg::*;
  localparam int CW = TMO_CYCLES == 0 ? 1 : $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TMO_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES == 0 ? 0 : TMO_CYCLES - 1);
  localparam logic [WORD_LENGTH-1:0] NOP = WORD_LENGTH'(NOP_INSTR);
  fetch_state_e state_q, state_d;
  trap_e trap_q, trap_d;
  logic [WORD_LENGTH-1:0] pst0_q, pst0_d, pst1_q, pst1_d, instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, accept, tmo, mis;
  assign iaReady = !rst && !flush &&
                   (state_q == FS_IDLE || (state_q == FS_HOLD && !fdStall && !pend_q));
  assign accept = iaValid && iaReady;
  assign mis = |iaPstate1[1:0];
  assign tmo = TMO_CYCLES != 0 && state_q == FS_WAIT && cnt_q == CNT_LAST;
  assign icReq = state_q == FS_REQ;
  assign fdValid = state_q == FS_HOLD;
  assign icSeg = pst0_q[SEG_W-1:0];
  assign icOfs = pst1_q;
  assign fdPstate0 = pst0_q;
  assign fdPstate1 = pst1_q;
  assign fdInstr = instr_q;
  assign fdTrap = trap_q != TRAP_NONE;
  assign fdTrapCode = trap_q;
  always_comb begin
    state_d = state_q;
    trap_d = trap_q;
    pst0_d = pst0_q;
    pst1_d = pst1_q;
    instr_d = instr_q;
    pend_d = pend_q && !icRspValid;
    cnt_d = (state_q == FS_WAIT && !flush) ? (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1) : '0;
    if (flush) begin
      pend_d = 1'b0;
      case (state_q)
        FS_REQ:   state_d = icReqAck ? FS_DRAIN : FS_IDLE;
        FS_WAIT:  state_d = icRspValid ? FS_IDLE : FS_DRAIN;
        FS_HOLD:  state_d = (pend_q && !icRspValid) ? FS_DRAIN : FS_IDLE;
        FS_DRAIN: state_d = icRspValid ? FS_IDLE : FS_DRAIN;
        default:  state_d = FS_IDLE;
      endcase
    end else if (accept) begin
      pst0_d = iaPstate0;
      pst1_d = iaPstate1;
      state_d = mis ? FS_HOLD : FS_REQ;
      trap_d = mis ? TRAP_ALIGN : TRAP_NONE;
      instr_d = mis ? NOP : instr_q;
    end else begin
      case (state_q)
        FS_REQ: state_d = icReqAck ? FS_WAIT : FS_REQ;
        FS_WAIT: begin
          // a timed-out request still owes a response; pend_q tracks it until it arrives
          state_d = (icRspValid || tmo) ? FS_HOLD : FS_WAIT;
          trap_d = icRspValid ? (icRspErr ? TRAP_ACCESS : TRAP_NONE) : (tmo ? TRAP_TMO : trap_q);
          instr_d = icRspValid ? (icRspErr ? NOP : icRspData) : (tmo ? NOP : instr_q);
          pend_d = !icRspValid && tmo;
        end
        FS_HOLD: begin
          state_d = fdStall ? FS_HOLD : ((pend_q && !icRspValid) ? FS_DRAIN : FS_IDLE);
          pend_d = fdStall && pend_q && !icRspValid;
        end
        FS_DRAIN: state_d = icRspValid ? FS_IDLE : FS_DRAIN;
        default:  state_d = FS_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      trap_q <= TRAP_NONE;
      pst0_q <= '0;
      pst1_q <= '0;
      instr_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q <= trap_d;
      pst0_q <= pst0_d;
      pst1_q <= pst1_d;
      instr_q <= instr_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors with hand-computed expectations, TMO_CYCLES=4
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic iaValid = 1'b0, flush = 1'b0, icReqAck = 1'b0, icRspValid = 1'b0, icRspErr = 1'b0, fdStall = 1'b0;
  logic [31:0] iaPstate0 = '0, iaPstate1 = '0, icRspData = '0;
  logic iaReady, icReq, fdValid, fdTrap;
  logic [15:0] icSeg;
  logic [31:0] icOfs, fdPstate0, fdPstate1, fdInstr;
  logic [1:0] fdTrapCode;
  int vecs = 0, errs = 0;

  instr_fetch_unit #(.TMO_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .iaValid(iaValid), .iaReady(iaReady), .iaPstate0(iaPstate0),
    .iaPstate1(iaPstate1), .flush(flush), .icReq(icReq), .icReqAck(icReqAck), .icSeg(icSeg),
    .icOfs(icOfs), .icRspValid(icRspValid), .icRspData(icRspData), .icRspErr(icRspErr),
    .fdValid(fdValid), .fdStall(fdStall), .fdPstate0(fdPstate0), .fdPstate1(fdPstate1),
    .fdInstr(fdInstr), .fdTrap(fdTrap), .fdTrapCode(fdTrapCode)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic fetch_req(input logic [31:0] p0, input logic [31:0] p1);
    @(negedge clk);
    iaValid = 1'b1; iaPstate0 = p0; iaPstate1 = p1;
    @(negedge clk);
    iaValid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    vecs++; if (iaReady !== 1'b0) begin errs++; $display("FAIL rst_iaReady got %b exp 0", iaReady); end
    vecs++; if ({icReq, fdValid, fdTrap} !== 3'b000) begin errs++; $display("FAIL rst_ctrl got %b exp 000", {icReq, fdValid, fdTrap}); end
    vecs++; if (fdTrapCode !== TRAP_NONE) begin errs++; $display("FAIL rst_code got %0d exp 0", fdTrapCode); end
    vecs++; if ({fdInstr, fdPstate0, fdPstate1} !== 96'h0) begin errs++; $display("FAIL rst_payload got %h exp 0", {fdInstr, fdPstate0, fdPstate1}); end
    rst = 1'b0;
    #1;
    vecs++; if (iaReady !== 1'b1) begin errs++; $display("FAIL rst_release_iaReady got %b exp 1", iaReady); end
  endtask

  task automatic test_basic;
    fetch_req(32'hABCD_0007, 32'h0000_1000);
    vecs++; if (icReq !== 1'b1) begin errs++; $display("FAIL basic_icReq got %b exp 1", icReq); end
    vecs++; if (icSeg !== 16'h0007 || icOfs !== 32'h1000) begin errs++; $display("FAIL basic_addr got %h/%h exp 0007/00001000", icSeg, icOfs); end
    icReqAck = 1'b1;
    @(negedge clk);
    icReqAck = 1'b0;
    vecs++; if (icReq !== 1'b0) begin errs++; $display("FAIL basic_icReq_fall got %b exp 0", icReq); end
    icRspValid = 1'b1; icRspData = 32'hDEAD_BEEF;
    @(negedge clk);
    icRspValid = 1'b0;
    vecs++; if (fdValid !== 1'b1 || fdTrap !== 1'b0) begin errs++; $display("FAIL basic_valid got %b%b exp 10", fdValid, fdTrap); end
    vecs++; if (fdInstr !== 32'hDEAD_BEEF) begin errs++; $display("FAIL basic_instr got %h exp deadbeef", fdInstr); end
    vecs++; if (fdPstate0 !== 32'hABCD_0007) begin errs++; $display("FAIL basic_pstate0 got %h exp abcd0007", fdPstate0); end
  endtask

  task automatic test_align;
    fetch_req(32'h0000_0001, 32'h0000_1002);
    vecs++; if (icReq !== 1'b0 || fdValid !== 1'b1) begin errs++; $display("FAIL align_ctrl got %b%b exp 01", icReq, fdValid); end
    vecs++; if (fdTrapCode !== TRAP_ALIGN || fdTrap !== 1'b1) begin errs++; $display("FAIL align_code got %0d/%b exp 1/1", fdTrapCode, fdTrap); end
    vecs++; if (fdInstr !== NOP_INSTR) begin errs++; $display("FAIL align_instr got %h exp %h", fdInstr, NOP_INSTR); end
  endtask

  task automatic test_stall;
    fetch_req(32'h0000_0002, 32'h0000_2002);
    fdStall = 1'b1; iaValid = 1'b1; iaPstate0 = 32'h0000_0009; iaPstate1 = 32'h0000_3000;
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++; if (iaReady !== 1'b0 || fdValid !== 1'b1) begin errs++; $display("FAIL stall_ready%0d got %b%b exp 01", i, iaReady, fdValid); end
      vecs++; if (fdPstate1 !== 32'h2002 || fdTrapCode !== TRAP_ALIGN) begin errs++; $display("FAIL stall_payload%0d got %h/%0d exp 00002002/1", i, fdPstate1, fdTrapCode); end
      @(negedge clk);
    end
    fdStall = 1'b0;
    #1;
    vecs++; if (iaReady !== 1'b1) begin errs++; $display("FAIL stall_release got %b exp 1", iaReady); end
    @(negedge clk);
    iaValid = 1'b0;
    vecs++; if (icReq !== 1'b1 || icOfs !== 32'h3000 || icSeg !== 16'h0009) begin errs++; $display("FAIL stall_next_req got %b %h %h exp 1 00003000 0009", icReq, icOfs, icSeg); end
    icReqAck = 1'b1;
    @(negedge clk);
    icReqAck = 1'b0; icRspValid = 1'b1; icRspData = 32'h3333_3333;
    @(negedge clk);
    icRspValid = 1'b0;
    vecs++; if (fdInstr !== 32'h3333_3333 || fdValid !== 1'b1) begin errs++; $display("FAIL stall_next_instr got %h/%b exp 33333333/1", fdInstr, fdValid); end
  endtask

  task automatic test_flush;
    fetch_req(32'h0, 32'h0000_4000);
    icReqAck = 1'b1;
    @(negedge clk);
    icReqAck = 1'b0; flush = 1'b1;
    #1;
    vecs++; if (iaReady !== 1'b0) begin errs++; $display("FAIL flush_iaReady got %b exp 0", iaReady); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    vecs++; if ({icReq, fdValid, iaReady} !== 3'b000) begin errs++; $display("FAIL flush_drain got %b exp 000", {icReq, fdValid, iaReady}); end
    icRspValid = 1'b1; icRspData = 32'h1111_1111;
    @(negedge clk);
    icRspValid = 1'b0;
    #1;
    vecs++; if (fdValid !== 1'b0 || iaReady !== 1'b1) begin errs++; $display("FAIL flush_discard got %b%b exp 01", fdValid, iaReady); end
    fetch_req(32'h0, 32'h0000_5000);
    icReqAck = 1'b1;
    @(negedge clk);
    icReqAck = 1'b0; icRspValid = 1'b1; icRspData = 32'h2222_2222;
    @(negedge clk);
    icRspValid = 1'b0;
    vecs++; if (fdInstr !== 32'h2222_2222 || fdValid !== 1'b1) begin errs++; $display("FAIL flush_new_instr got %h/%b exp 22222222/1", fdInstr, fdValid); end
  endtask

  task automatic test_access_tmo;
    fetch_req(32'h0, 32'h0000_6000);
    icReqAck = 1'b1;
    @(negedge clk);
    icReqAck = 1'b0; icRspValid = 1'b1; icRspErr = 1'b1; icRspData = 32'h5555_5555;
    @(negedge clk);
    icRspValid = 1'b0; icRspErr = 1'b0;
    vecs++; if (fdTrapCode !== TRAP_ACCESS || fdInstr !== NOP_INSTR) begin errs++; $display("FAIL access_trap got %0d/%h exp 2/%h", fdTrapCode, fdInstr, NOP_INSTR); end
    fetch_req(32'h0, 32'h0000_7000);
    icReqAck = 1'b1;
    @(negedge clk);
    icReqAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vecs++; if (fdValid !== 1'b0) begin errs++; $display("FAIL tmo_early%0d got %b exp 0", i, fdValid); end
    end
    @(negedge clk);
    fdStall = 1'b1;
    vecs++; if (fdValid !== 1'b1 || fdTrapCode !== TRAP_TMO) begin errs++; $display("FAIL tmo_trap got %b/%0d exp 1/3", fdValid, fdTrapCode); end
    @(negedge clk);
    icRspValid = 1'b1; icRspData = 32'h6666_6666;
    @(negedge clk);
    icRspValid = 1'b0;
    vecs++; if (fdInstr !== NOP_INSTR || fdTrapCode !== TRAP_TMO) begin errs++; $display("FAIL tmo_late_rsp got %h/%0d exp %h/3", fdInstr, fdTrapCode, NOP_INSTR); end
    fdStall = 1'b0;
    @(negedge clk);
    #1;
    vecs++; if (fdValid !== 1'b0 || iaReady !== 1'b1) begin errs++; $display("FAIL tmo_idle got %b%b exp 01", fdValid, iaReady); end
  endtask

  task automatic test_rst_flush;
    fetch_req(32'h0000_0003, 32'h0000_8000);
    rst = 1'b1;
    @(negedge clk);
    #1;
    vecs++; if ({icReq, fdValid, iaReady, fdTrap} !== 4'b0000) begin errs++; $display("FAIL mid_rst_ctrl got %b exp 0000", {icReq, fdValid, iaReady, fdTrap}); end
    vecs++; if (fdPstate1 !== 32'h0 || fdTrapCode !== TRAP_NONE) begin errs++; $display("FAIL mid_rst_payload got %h/%0d exp 0/0", fdPstate1, fdTrapCode); end
    rst = 1'b0;
    fetch_req(32'h0, 32'h0000_9000);
    flush = 1'b1; icReqAck = 1'b1;
    @(negedge clk);
    flush = 1'b0; icReqAck = 1'b0;
    #1;
    vecs++; if ({icReq, iaReady} !== 2'b00) begin errs++; $display("FAIL ack_flush_drain got %b exp 00", {icReq, iaReady}); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    vecs++; if (iaReady !== 1'b0) begin errs++; $display("FAIL drain_flush_absorb got %b exp 0", iaReady); end
    icRspValid = 1'b1;
    @(negedge clk);
    icRspValid = 1'b0;
    #1;
    vecs++; if (iaReady !== 1'b1 || fdValid !== 1'b0) begin errs++; $display("FAIL drain_exit got %b%b exp 10", iaReady, fdValid); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_align;
    test_stall;
    test_flush;
    test_access_tmo;
    test_rst_flush;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
